// File: rtl/genius_seq_engine.sv
// Genius memory-game sequence engine: LFSR symbol generation, tick-paced playback, press checking.
// Optional press timeout is compiled in with `define GENIUS_TIMEOUT_EN.
module genius_seq_engine #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned MAX_ROUNDS    = 16,
  parameter int unsigned TIMEOUT_TICKS = 5,
  localparam int unsigned SYM_W        = $clog2(N_CH),
  localparam int unsigned ROUND_W      = $clog2(MAX_ROUNDS + 1)
) (
  input  logic               CLOCK_50,
  input  logic               R,
  input  logic               start,
  input  logic [15:0]        seed,
  input  logic               tick,
  input  logic [N_CH-1:0]    btn,
  output logic [N_CH-1:0]    led,
  output logic [ROUND_W-1:0] round,
  output logic               playing,
  output logic               awaiting,
  output logic               match,
  output logic               win,
  output logic               lose
);

  localparam int unsigned ADDR_W = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [2:0] {
    StIdle, StGen, StShowOn, StShowOff, StWaitUser, StWin, StLose
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d, lfsr_step;
  logic [ROUND_W-1:0] round_len_q, round_len_d;
  logic [ROUND_W-1:0] idx_q, idx_d, idx_inc;
  logic               match_q, match_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               mem_we;
  logic               idx_last;
  logic [SYM_W-1:0]   cur_sym;
  logic [N_CH-1:0]    exp_oh;

  logic [SYM_W-1:0]   seq_mem [DEPTH];

`ifdef GENIUS_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_TICKS == 0);
`endif

  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign idx_inc   = idx_q + ROUND_W'(1);
  assign idx_last  = (idx_inc == round_len_q);
  assign cur_sym   = seq_mem[idx_q[ADDR_W-1:0]];

  // Sequence buffer has no reset; every entry is written in GEN before it is read.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) begin
      seq_mem[round_len_q[ADDR_W-1:0]] <= lfsr_step[SYM_W-1:0];
    end
  end

  always_comb begin
    exp_oh          = '0;
    exp_oh[cur_sym] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    round_len_d = round_len_q;
    idx_d       = idx_q;
    match_d     = 1'b0;
    win_d       = win_q;
    lose_d      = lose_q;
    mem_we      = 1'b0;
`ifdef GENIUS_TIMEOUT_EN
    tcnt_d      = tcnt_q;
`endif
    unique case (state_q)
      StIdle, StWin, StLose: begin
        if (start) begin
          lfsr_d      = (seed == 16'h0000) ? LFSR_INIT : seed;
          round_len_d = '0;
          win_d       = 1'b0;
          lose_d      = 1'b0;
          state_d     = StGen;
        end
      end
      StGen: begin
        lfsr_d      = lfsr_step;
        mem_we      = 1'b1;
        round_len_d = round_len_q + ROUND_W'(1);
        idx_d       = '0;
        state_d     = StShowOn;
      end
      StShowOn: begin
        if (tick) state_d = StShowOff;
      end
      StShowOff: begin
        if (tick) begin
          if (idx_last) begin
            idx_d   = '0;
`ifdef GENIUS_TIMEOUT_EN
            tcnt_d  = '0;
`endif
            state_d = StWaitUser;
          end else begin
            idx_d   = idx_inc;
            state_d = StShowOn;
          end
        end
      end
      StWaitUser: begin
        if (btn != '0) begin
          // exp_oh is one-hot, so equality also rejects multi-hot presses.
          if (btn != exp_oh) begin
            lose_d  = 1'b1;
            state_d = StLose;
          end else begin
            idx_d = idx_inc;
`ifdef GENIUS_TIMEOUT_EN
            tcnt_d = '0;
`endif
            if (idx_last) begin
              match_d = 1'b1;
              if (round_len_q == ROUND_W'(MAX_ROUNDS)) begin
                win_d   = 1'b1;
                state_d = StWin;
              end else begin
                state_d = StGen;
              end
            end
          end
        end
`ifdef GENIUS_TIMEOUT_EN
        else if (tick) begin
          if (tcnt_q == TCNT_W'(TIMEOUT_TICKS - 1)) begin
            lose_d  = 1'b1;
            state_d = StLose;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge R) begin
    if (R) begin
      state_q     <= StIdle;
      lfsr_q      <= LFSR_INIT;
      round_len_q <= '0;
      idx_q       <= '0;
      match_q     <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
`ifdef GENIUS_TIMEOUT_EN
      tcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      round_len_q <= round_len_d;
      idx_q       <= idx_d;
      match_q     <= match_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
`ifdef GENIUS_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
`endif
    end
  end

  always_comb begin
    led = '0;
    if (state_q == StShowOn) led = exp_oh;
  end

  assign playing  = (state_q == StShowOn) || (state_q == StShowOff);
  assign awaiting = (state_q == StWaitUser);
  assign round    = round_len_q;
  assign match    = match_q;
  assign win      = win_q;
  assign lose     = lose_q;

endmodule

// File: tb/tb_genius_seq_engine.sv
// Scoreboard bench for genius_seq_engine: a sequence model queues expected display/match/win/lose
// events, and a forked monitor pops and compares them as the DUT produces them.
module tb_genius_seq_engine;

  localparam int N_CH          = 4;
  localparam int MAX_ROUNDS    = 4;
  localparam int TIMEOUT_TICKS = 5;
  localparam int ROUND_W       = $clog2(MAX_ROUNDS + 1);

  localparam int EV_SHOW  = 0;
  localparam int EV_MATCH = 1;
  localparam int EV_WIN   = 2;
  localparam int EV_LOSE  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [15:0]        seed;
  logic               tick;
  logic [N_CH-1:0]    btn;
  logic [N_CH-1:0]    led;
  logic [ROUND_W-1:0] round;
  logic               playing, awaiting, match, win, lose;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t         exp_q[$];
  int          seq[$];
  logic [15:0] lf;
  int          checks = 0;
  int          errors = 0;

  genius_seq_engine #(
    .N_CH          (N_CH),
    .MAX_ROUNDS    (MAX_ROUNDS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .CLOCK_50 (clk),
    .R        (rst),
    .start    (start),
    .seed     (seed),
    .tick     (tick),
    .btn      (btn),
    .led      (led),
    .round    (round),
    .playing  (playing),
    .awaiting (awaiting),
    .match    (match),
    .win      (win),
    .lose     (lose)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      EV_SHOW:  return "show";
      EV_MATCH: return "match";
      EV_WIN:   return "win";
      default:  return "lose";
    endcase
  endfunction

  // Reference LFSR: shift left, feedback is the parity of taps 15, 13, 12, 10.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int fb;
    fb = (int'(s[15]) + int'(s[13]) + int'(s[12]) + int'(s[10])) % 2;
    return 16'((int'(s) * 2) % 65536 + fb);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input int v);
    exp_q.push_back('{kind: k, val: v});
  endtask

  task automatic got(input int k, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got %0d expected no event", kname(k), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL event: got %s %0d expected %s %0d", kname(k), v, kname(e.kind), e.val);
      end
    end
  endtask

  task automatic monitor();
    logic [N_CH-1:0] led_prev = '0;
    logic            win_prev = 1'b0;
    logic            lose_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (led != '0 && led_prev == '0) got(EV_SHOW, int'(led));
        if (match) got(EV_MATCH, int'(round));
        if (win && !win_prev) got(EV_WIN, int'(round));
        if (lose && !lose_prev) got(EV_LOSE, int'(round));
      end
      led_prev  = led;
      win_prev  = win;
      lose_prev = lose;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] sd);
    seed  = sd;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic press(input logic [N_CH-1:0] v);
    btn = v;
    step();
    btn = '0;
  endtask

  task automatic model_reset(input logic [15:0] sd);
    lf = (sd == 16'h0000) ? 16'hACE1 : sd;
    seq.delete();
  endtask

  task automatic model_new_round();
    lf = lfsr_next(lf);
    seq.push_back(int'(lf) % N_CH);
    foreach (seq[i]) expect_ev(EV_SHOW, 1 << seq[i]);
  endtask

  // Ticks until WAIT_USER, with stray presses that must be ignored while not awaiting.
  task automatic run_playback();
    int n = 0;
    while (!awaiting && n < 4 * MAX_ROUNDS + 8) begin
      if ($urandom_range(0, 3) == 0) btn = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      tick = 1'b1;
      step();
      tick = 1'b0;
      btn  = '0;
      repeat ($urandom_range(0, 2)) step();
      n++;
    end
    check("reach_wait_user", int'(awaiting), 1);
    check("led_in_wait", int'(led), 0);
  endtask

  task automatic play_game(input logic [15:0] sd, input int err_round, input int err_pos,
                           input bit multi);
    do_start(sd);
    check("round_cleared", int'(round), 0);
    check("win_cleared", int'(win), 0);
    check("lose_cleared", int'(lose), 0);
    model_reset(sd);
    for (int r = 1; r <= MAX_ROUNDS; r++) begin
      model_new_round();
      run_playback();
      check("round_len", int'(round), r);
      if ($urandom_range(0, 2) == 0) do_start(16'($urandom));
      for (int p = 0; p < r; p++) begin
        int oh = 1 << seq[p];
        repeat ($urandom_range(0, 2)) step();
        if (r == err_round && p == err_pos) begin
          int bad = multi ? (oh | (1 << ((seq[p] + 1) % N_CH)))
                          : (1 << ((seq[p] + 1 + $urandom_range(0, N_CH - 2)) % N_CH));
          expect_ev(EV_LOSE, r);
          press(N_CH'(bad));
          check("lose_level", int'(lose), 1);
          check("led_after_lose", int'(led), 0);
          check("awaiting_after_lose", int'(awaiting), 0);
          return;
        end
        if (p == r - 1) begin
          expect_ev(EV_MATCH, r);
          if (r == MAX_ROUNDS) expect_ev(EV_WIN, r);
        end
        press(N_CH'(oh));
      end
    end
    check("win_level", int'(win), 1);
    check("round_at_win", int'(round), MAX_ROUNDS);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tick  = 1'b0;
    btn   = '0;
    seed  = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", int'(led), 0);
    check("rst_round", int'(round), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_awaiting", int'(awaiting), 0);
    check("rst_match", int'(match), 0);
    check("rst_win", int'(win), 0);
    check("rst_lose", int'(lose), 0);
    rst = 1'b0;
    step();

    play_game(16'h0001, 0, 0, 1'b0);
    play_game(16'($urandom), 1, 0, 1'b0);
    play_game(16'($urandom), 3, 1, 1'b1);
    play_game(16'h0000, 0, 0, 1'b0);
    for (int g = 0; g < 6; g++) begin
      int er = $urandom_range(1, MAX_ROUNDS + 1);
      play_game(16'($urandom), er, $urandom_range(0, er - 1), 1'($urandom_range(0, 1)));
    end

`ifdef GENIUS_TIMEOUT_EN
    do_start(16'h0001);
    model_reset(16'h0001);
    model_new_round();
    run_playback();
    repeat (TIMEOUT_TICKS - 1) tick_once();
    check("no_early_timeout", int'(awaiting), 1);
    expect_ev(EV_LOSE, 1);
    tick_once();
    check("timeout_lose", int'(lose), 1);

    do_start(16'h0001);
    model_reset(16'h0001);
    model_new_round();
    run_playback();
    expect_ev(EV_MATCH, 1);
    press(N_CH'(1 << seq[0]));
    model_new_round();
    run_playback();
    repeat (TIMEOUT_TICKS - 2) tick_once();
    tick = 1'b1;
    btn  = N_CH'(1 << seq[0]);
    step();
    tick = 1'b0;
    btn  = '0;
    repeat (TIMEOUT_TICKS - 1) tick_once();
    check("press_restarts_timeout", int'(awaiting), 1);
    check("press_restarts_no_lose", int'(lose), 0);
    expect_ev(EV_LOSE, 2);
    tick_once();
    check("timeout_lose_after_press", int'(lose), 1);
`else
    do_start(16'h0001);
    model_reset(16'h0001);
    model_new_round();
    run_playback();
    repeat (3 * TIMEOUT_TICKS) tick_once();
    check("waits_forever", int'(awaiting), 1);
    check("no_timeout_lose", int'(lose), 0);
    expect_ev(EV_LOSE, 1);
    press(N_CH'(1 << ((seq[0] + 1) % N_CH)));
    check("lose_after_wait", int'(lose), 1);
`endif

    do_start(16'h1234);
    model_reset(16'h1234);
    lf = lfsr_next(lf);
    expect_ev(EV_SHOW, 1 << (int'(lf) % N_CH));
    step();
    check("show_on_playing", int'(playing), 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_round", int'(round), 0);
    check("async_rst_playing", int'(playing), 0);
    check("async_rst_win", int'(win), 0);
    check("async_rst_lose", int'(lose), 0);
    step();
    rst = 1'b0;
    press(4'b0001);
    press(4'b1000);
    repeat (2) tick_once();
    check("idle_after_rst_awaiting", int'(awaiting), 0);
    check("idle_after_rst_round", int'(round), 0);
    check("idle_after_rst_lose", int'(lose), 0);
    step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
